sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter N_SW, default 2: number of independent switch/button channels, range 1..16.
REQ-002 Parameter DB_CYCLES, default 500_000: debounce window in clock cycles (10 ms at 50 MHz), minimum 2; the bench overrides it to a small value.
REQ-003 CLK  input  1  system clock; every register is updated on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 sw_in  input  N_SW  raw asynchronous switch/button levels, one bit per channel.
REQ-006 sw_level  output  N_SW  debounced level, registered.
REQ-007 sw_rise  output  N_SW  one-cycle pulse on each debounced 0->1 transition.
REQ-008 sw_fall  output  N_SW  one-cycle pulse on each debounced 1->0 transition.
REQ-009 sw_toggle  output  N_SW  level that inverts on every sw_rise of its channel.
REQ-010 sw_busy  output  N_SW  high while the channel's debounce counter is nonzero.

Function
REQ-011 Each channel shall pass sw_in through a 2-flop synchronizer (s1, s2); only s2 shall be used by the channel logic.
REQ-012 Each channel shall hold a counter of width $clog2(DB_CYCLES) and a state machine with states LO, WAIT_HI, HI and WAIT_LO.
REQ-013 LO: on s2=1, go to WAIT_HI with counter=1; otherwise stay in LO with counter=0.
REQ-014 WAIT_HI: on s2=0, return to LO with counter=0. On s2=1 with counter=DB_CYCLES-1, go to HI, counter=0, sw_level=1, sw_rise=1 for one cycle, sw_toggle inverted. Otherwise counter+1.
REQ-015 HI/WAIT_LO: mirror of REQ-013/014 with levels inverted; entering LO sets sw_level=0 and sw_fall=1 for one cycle; sw_toggle unchanged.
REQ-016 Latency: with the first rising edge that samples a stable new sw_in value numbered edge 1, sw_level, sw_rise and sw_fall shall update at edge DB_CYCLES+2.
REQ-017 Glitch rejection: an s2 excursion lasting fewer than DB_CYCLES consecutive cycles shall produce no change on any output except sw_busy.
REQ-018 Bounce: any cycle in which s2 equals sw_level shall clear the counter, so the debounce window restarts from zero.
REQ-019 sw_rise and sw_fall shall never both be high on a channel, and neither shall stay high for two consecutive cycles.
REQ-020 Channels shall be fully independent; simultaneous transitions on several channels shall each produce their own pulses in the same cycle.
REQ-021 The counter shall never exceed DB_CYCLES-1 and shall never wrap.
REQ-022 sw_busy shall equal (counter != 0), registered together with the counter.

Reset
REQ-023 While RST=1 at a rising edge, the following shall be cleared to 0 on that edge: s1, s2, all counters, sw_level, sw_rise, sw_fall, sw_toggle and sw_busy. All states shall be set to LO.
REQ-024 RST asserted in the middle of a debounce window shall abort it; no pulse shall be emitted for that window.
REQ-025 If sw_in is held at 1 through the release of RST, the channel shall debounce it as a new transition: sw_level goes to 1 and sw_rise pulses DB_CYCLES+2 edges after release.
REQ-026 Reset shall have priority over every other update in the same cycle.

Verification (DB_CYCLES=8, N_SW=2)
REQ-027 Clean press: sw_in[0] 0->1 and held -> sw_level[0]=1 and sw_rise[0] high for exactly one cycle at edge 10; sw_toggle[0]=1.
REQ-028 Glitch: sw_in[0]=1 for 7 cycles, then 0 -> sw_level[0] stays 0; no rise/fall pulses; sw_busy[0] high for 7 cycles, then low.
REQ-029 Bounce: sw_in[1] 1,0,1,1,0,1 then held 1 -> exactly one sw_rise[1], 8 cycles after the s2 level last becomes 1 and stays there; after release, exactly one sw_fall[1].
REQ-030 Simultaneous: both channels 0->1 on the same edge -> sw_rise=2'b11 in the same cycle; sw_toggle=2'b11; two further press/release cycles on channel 0 -> sw_toggle[0] returns to 1 after the third press.
REQ-031 Reset mid-window: press channel 0, assert RST at edge 6 for 1 cycle with sw_in held at 1 -> all outputs 0; sw_rise[0] fires 10 edges after RST deasserts.
REQ-032 Property checks for the whole run: rise/fall mutually exclusive and one cycle wide; counter never exceeds 7; sw_level changes only in the same cycle as a rise or fall pulse.

Source files
------------

// File: rtl/sw_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_if
// Description : Switch-level bundle between the raw switch source and the
//               debouncer: raw levels in, debounced levels/pulses out.
// Revision    : 1.0
// ============================================================================
interface sw_debounce_if #(
    parameter int N_SW = 2
);
    logic [N_SW-1:0] sw_in;
    logic [N_SW-1:0] sw_level;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;
    logic [N_SW-1:0] sw_toggle;
    logic [N_SW-1:0] sw_busy;

    modport master (
        output sw_in,
        input  sw_level,
        input  sw_rise,
        input  sw_fall,
        input  sw_toggle,
        input  sw_busy
    );

    modport slave (
        input  sw_in,
        output sw_level,
        output sw_rise,
        output sw_fall,
        output sw_toggle,
        output sw_busy
    );
endinterface
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : N-channel switch debouncer with 2-flop synchronizer, debounced
//               level, rise/fall pulses, press toggle and busy flag.
// Revision    : 1.0
// ============================================================================
module sw_debounce #(
    parameter int N_SW      = 2,
    parameter int DB_CYCLES = 500_000
) (
    input  wire logic   CLK,
    input  wire logic   RST,
    sw_debounce_if.slave bus
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        LO      = 2'd0,
        WAIT_HI = 2'd1,
        HI      = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    logic [N_SW-1:0]  r_s1;
    logic [N_SW-1:0]  r_s2;
    state_t           r_state [N_SW];
    logic [CNT_W-1:0] r_cnt   [N_SW];
    logic [N_SW-1:0]  r_level;
    logic [N_SW-1:0]  r_rise;
    logic [N_SW-1:0]  r_fall;
    logic [N_SW-1:0]  r_toggle;
    logic [N_SW-1:0]  r_busy;

    state_t           w_state [N_SW];
    logic [CNT_W-1:0] w_cnt   [N_SW];
    logic [N_SW-1:0]  w_level;
    logic [N_SW-1:0]  w_rise;
    logic [N_SW-1:0]  w_fall;
    logic [N_SW-1:0]  w_toggle;
    logic [N_SW-1:0]  w_busy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_level  <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_toggle <= '0;
            r_busy   <= '0;
            for (int i = 0; i < N_SW; i++) begin
                r_state[i] <= LO;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_s1     <= bus.sw_in;
            r_s2     <= r_s1;
            r_level  <= w_level;
            r_rise   <= w_rise;
            r_fall   <= w_fall;
            r_toggle <= w_toggle;
            r_busy   <= w_busy;
            for (int i = 0; i < N_SW; i++) begin
                r_state[i] <= w_state[i];
                r_cnt[i]   <= w_cnt[i];
            end
        end
    end

    // Any sample where s2 agrees with the current level drops back to a
    // settled state with the counter cleared, restarting the window.
    always_comb begin
        w_level  = r_level;
        w_rise   = '0;
        w_fall   = '0;
        w_toggle = r_toggle;
        w_busy   = '0;
        for (int i = 0; i < N_SW; i++) begin
            w_state[i] = r_state[i];
            w_cnt[i]   = '0;
            case (r_state[i])
                LO: begin
                    if (r_s2[i]) begin
                        w_state[i] = WAIT_HI;
                        w_cnt[i]   = c_CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!r_s2[i]) begin
                        w_state[i] = LO;
                    end else if (r_cnt[i] == c_CNT_MAX) begin
                        w_state[i]  = HI;
                        w_level[i]  = 1'b1;
                        w_rise[i]   = 1'b1;
                        w_toggle[i] = ~r_toggle[i];
                    end else begin
                        w_cnt[i] = r_cnt[i] + c_CNT_ONE;
                    end
                end
                HI: begin
                    if (!r_s2[i]) begin
                        w_state[i] = WAIT_LO;
                        w_cnt[i]   = c_CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (r_s2[i]) begin
                        w_state[i] = HI;
                    end else if (r_cnt[i] == c_CNT_MAX) begin
                        w_state[i] = LO;
                        w_level[i] = 1'b0;
                        w_fall[i]  = 1'b1;
                    end else begin
                        w_cnt[i] = r_cnt[i] + c_CNT_ONE;
                    end
                end
            endcase
            w_busy[i] = (w_cnt[i] != '0);
        end
    end

    assign bus.sw_level  = r_level;
    assign bus.sw_rise   = r_rise;
    assign bus.sw_fall   = r_fall;
    assign bus.sw_toggle = r_toggle;
    assign bus.sw_busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_debounce
// Description : Self-checking bench for sw_debounce: directed scenarios plus
//               randomized switch activity against a run-length reference.
// Revision    : 1.0
// ============================================================================
module tb_sw_debounce;

    localparam int N  = 2;
    localparam int DB = 8;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    sw_debounce_if #(.N_SW(N)) bus ();

    sw_debounce #(.N_SW(N), .DB_CYCLES(DB)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a channel's level flips once s2 has disagreed with it for
    // DB consecutive samples; busy is "a disagreement run is in progress".
    logic [N-1:0] m_s1, m_s2, m_level, m_rise, m_fall, m_tog, m_busy;
    int           m_run [N];
    logic         m_was_rst = 1'b1;

    always @(posedge CLK) begin
        m_was_rst = RST;
        if (RST) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0;
            m_fall = '0; m_tog = '0; m_busy = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (m_s2[i] != m_level[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB) begin
                        m_level[i] = m_s2[i];
                        m_run[i]   = 0;
                        if (m_level[i]) begin
                            m_rise[i] = 1'b1;
                            m_tog[i]  = ~m_tog[i];
                        end else begin
                            m_fall[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_busy[i] = (m_run[i] != 0);
            end
            m_s2 = m_s1;
            m_s1 = bus.sw_in;
        end
    end

    logic         chk_en = 1'b0;
    logic [N-1:0] p_rise = '0, p_level = '0;
    int           busy_run [N];

    always @(negedge CLK) begin
        if (chk_en) begin
            check("level",  bus.sw_level,  m_level);
            check("rise",   bus.sw_rise,   m_rise);
            check("fall",   bus.sw_fall,   m_fall);
            check("toggle", bus.sw_toggle, m_tog);
            check("busy",   bus.sw_busy,   m_busy);
            check("rf_excl", bus.sw_rise & bus.sw_fall, 0);
            check("rise_wide", bus.sw_rise & p_rise, 0);
            if (!m_was_rst)
                check("lvl_no_pulse", (bus.sw_level ^ p_level) & ~(bus.sw_rise | bus.sw_fall), 0);
            for (int i = 0; i < N; i++) begin
                busy_run[i] = bus.sw_busy[i] ? busy_run[i] + 1 : 0;
                check("busy_len", busy_run[i] > DB - 1, 0);
            end
        end
        p_rise  = bus.sw_rise;
        p_level = bus.sw_level;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
    endtask

    int cnt_a, cnt_b;
    logic seen;
    logic [5:0] bounce;

    initial begin
        for (int i = 0; i < N; i++) busy_run[i] = 0;
        RST = 1'b1;
        bus.sw_in = '0;
        tick(3);
        chk_en = 1'b1;
        check("rst_level",  bus.sw_level,  0);
        check("rst_toggle", bus.sw_toggle, 0);
        check("rst_busy",   bus.sw_busy,   0);
        RST = 1'b0;
        tick(4);

        // Clean press on channel 0: rise exactly at edge DB+2.
        bus.sw_in = 2'b01;
        for (int e = 1; e <= 12; e++) begin
            tick(1);
            check("press_rise_edge", bus.sw_rise[0], (e == DB + 2));
        end
        check("press_level",  bus.sw_level[0],  1);
        check("press_toggle", bus.sw_toggle[0], 1);
        bus.sw_in = 2'b00;
        tick(14);
        check("release_level", bus.sw_level[0], 0);

        // Glitch of DB-1 cycles: busy for DB-1 cycles, no pulses.
        cnt_a = 0; cnt_b = 0;
        bus.sw_in = 2'b01;
        for (int k = 0; k < DB - 1; k++) begin
            tick(1);
            cnt_a += bus.sw_busy[0];
            cnt_b += bus.sw_rise[0] + bus.sw_fall[0];
        end
        bus.sw_in = 2'b00;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            cnt_a += bus.sw_busy[0];
            cnt_b += bus.sw_rise[0] + bus.sw_fall[0];
        end
        check("glitch_busy_cycles", cnt_a, DB - 1);
        check("glitch_pulses", cnt_b, 0);
        check("glitch_level", bus.sw_level[0], 0);

        // Bounce on channel 1, then hold; then release.
        bounce = 6'b101101;
        cnt_a = 0; cnt_b = 0;
        for (int k = 5; k >= 0; k--) begin
            bus.sw_in[1] = bounce[k];
            tick(1);
            cnt_a += bus.sw_rise[1];
        end
        bus.sw_in[1] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            tick(1);
            cnt_a += bus.sw_rise[1];
            cnt_b += bus.sw_fall[1];
        end
        check("bounce_rises", cnt_a, 1);
        check("bounce_falls_while_held", cnt_b, 0);
        bus.sw_in[1] = 1'b0;
        cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            cnt_b += bus.sw_fall[1];
        end
        check("bounce_release_falls", cnt_b, 1);

        // Simultaneous press on both channels.
        do_reset();
        tick(2);
        bus.sw_in = 2'b11;
        seen = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick(1);
            if (bus.sw_rise == 2'b11) seen = 1'b1;
        end
        check("simul_rise_same_cycle", seen, 1);
        check("simul_toggle", bus.sw_toggle, 2'b11);
        bus.sw_in = 2'b00;
        tick(14);
        bus.sw_in = 2'b01; tick(14);
        check("toggle_2nd_press", bus.sw_toggle[0], 0);
        bus.sw_in = 2'b00; tick(14);
        bus.sw_in = 2'b01; tick(14);
        check("toggle_3rd_press", bus.sw_toggle[0], 1);
        bus.sw_in = 2'b00; tick(14);

        // Reset in the middle of a debounce window with the input held high.
        do_reset();
        tick(3);
        bus.sw_in = 2'b01;
        tick(5);
        RST = 1'b1;
        tick(1);
        check("midrst_level", bus.sw_level, 0);
        check("midrst_busy",  bus.sw_busy,  0);
        check("midrst_rise",  bus.sw_rise,  0);
        RST = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick(1);
            check("midrst_rise_edge", bus.sw_rise[0], (e == DB + 2));
        end
        bus.sw_in = 2'b00;
        tick(14);

        // Randomized activity with occasional resets.
        for (int seg = 0; seg < 250; seg++) begin
            bus.sw_in = N'($urandom);
            if ($urandom_range(0, 39) == 0) RST = 1'b1;
            tick(1);
            RST = 1'b0;
            tick($urandom_range(0, 3 * DB));
        end
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
